// File: rtl/multicycle_alu.sv
// Multicycle ALU: single-cycle arithmetic/logic/shift ops complete in one
// cycle; MUL (shift-add), DIVU/REMU (restoring division) iterate WIDTH times.
// Valid/ready handshake on both sides; result and flags are registered.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OPW-1:0]   alu_control,
    input  logic [WIDTH-1:0] operand0,
    input  logic [WIDTH-1:0] operand1,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             carryflag,
    output logic             signflag,
    output logic             overflowflag,
    output logic             zflag,
    output logic             errflag
);
    localparam int SHW  = $clog2(WIDTH);
    localparam int CNTW = $clog2(WIDTH + 1);
    localparam int MSB  = WIDTH - 1;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

    localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
    localparam logic [OPW-1:0] OP_COMP = OPW'(1);
    localparam logic [OPW-1:0] OP_AND  = OPW'(2);
    localparam logic [OPW-1:0] OP_XOR  = OPW'(3);
    localparam logic [OPW-1:0] OP_SLL  = OPW'(4);
    localparam logic [OPW-1:0] OP_SRL  = OPW'(5);
    localparam logic [OPW-1:0] OP_SRA  = OPW'(6);
    localparam logic [OPW-1:0] OP_SUB  = OPW'(7);
    localparam logic [OPW-1:0] OP_MUL  = OPW'(8);
    localparam logic [OPW-1:0] OP_DIVU = OPW'(9);
    localparam logic [OPW-1:0] OP_REMU = OPW'(10);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [OPW-1:0]    op_q, op_d;
    logic [WIDTH-1:0]  a_q, a_d;      // multiplicand or divisor
    logic [WIDTH-1:0]  acc_q, acc_d;  // product high half or partial remainder
    logic [WIDTH-1:0]  b_q, b_d;      // multiplier/product low half or dividend/quotient
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic              carry_q, carry_d;
    logic              sign_q, sign_d;
    logic              ovf_q, ovf_d;
    logic              z_q, z_d;
    logic              err_q, err_d;

    logic [WIDTH:0]    sum_s, diff_s;
    logic [SHW-1:0]    sh_s;
    logic [WIDTH-1:0]  sc_result_s;
    logic              sc_carry_s, sc_ovf_s, sc_err_s, sc_multi_s;
    logic [WIDTH:0]    mul_sum_s;
    logic [WIDTH:0]    div_shift_s;
    logic              div_ge_s;
    logic [WIDTH-1:0]  div_sub_s;
    logic [WIDTH-1:0]  fin_res_s;
    logic              accept_s;

    // Single-cycle result/flags straight from the request inputs, plus the
    // decision whether the request needs the iterative datapath.
    always_comb begin
        sum_s       = {1'b0, operand0} + {1'b0, operand1};
        diff_s      = {1'b0, operand0} - {1'b0, operand1};
        sh_s        = operand1[SHW-1:0];
        sc_result_s = '0;
        sc_carry_s  = 1'b0;
        sc_ovf_s    = 1'b0;
        sc_err_s    = 1'b0;
        sc_multi_s  = 1'b0;
        case (alu_control)
            OP_ADD: begin
                sc_result_s = sum_s[WIDTH-1:0];
                sc_carry_s  = sum_s[WIDTH];
                sc_ovf_s    = (operand0[MSB] == operand1[MSB]) && (sum_s[MSB] != operand0[MSB]);
            end
            OP_COMP: sc_result_s = ~operand1 + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_AND:  sc_result_s = operand0 & operand1;
            OP_XOR:  sc_result_s = operand0 ^ operand1;
            OP_SLL:  sc_result_s = operand0 << sh_s;
            OP_SRL:  sc_result_s = operand0 >> sh_s;
            OP_SRA:  sc_result_s = $signed(operand0) >>> sh_s;
            OP_SUB: begin
                sc_result_s = diff_s[WIDTH-1:0];
                sc_carry_s  = ~diff_s[WIDTH];  // set when no borrow
                sc_ovf_s    = (operand0[MSB] != operand1[MSB]) && (diff_s[MSB] != operand0[MSB]);
            end
            OP_MUL: sc_multi_s = 1'b1;
            OP_DIVU: begin
                if (operand1 == '0) begin
                    sc_result_s = '1;
                    sc_err_s    = 1'b1;
                end else begin
                    sc_multi_s = 1'b1;
                end
            end
            OP_REMU: begin
                if (operand1 == '0) begin
                    sc_result_s = operand0;
                    sc_err_s    = 1'b1;
                end else begin
                    sc_multi_s = 1'b1;
                end
            end
            default: sc_err_s = 1'b1;  // illegal opcode: zero result, error
        endcase
    end

    // One shift-add step and one restoring-division step on the held operands.
    always_comb begin
        mul_sum_s   = {1'b0, acc_q} + (b_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});
        div_shift_s = {acc_q, b_q[MSB]};
        div_ge_s    = div_shift_s >= {1'b0, a_q};
        div_sub_s   = div_shift_s[WIDTH-1:0] - a_q;
    end

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        acc_d     = acc_q;
        b_d       = b_q;
        result_d  = result_q;
        carry_d   = carry_q;
        sign_d    = sign_q;
        ovf_d     = ovf_q;
        z_d       = z_q;
        err_d     = err_q;
        fin_res_s = '0;
        accept_s  = in_valid && in_ready_q;
        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    op_d  = alu_control;
                    cnt_d = '0;
                    if (sc_multi_s) begin
                        state_d = BUSY;
                        acc_d   = '0;
                        if (alu_control == OP_MUL) begin
                            a_d = operand0;
                            b_d = operand1;
                        end else begin
                            a_d = operand1;
                            b_d = operand0;
                        end
                    end else begin
                        state_d  = DONE;
                        result_d = sc_result_s;
                        carry_d  = sc_carry_s;
                        ovf_d    = sc_ovf_s;
                        sign_d   = sc_result_s[MSB] ^ sc_ovf_s;
                        z_d      = (sc_result_s == '0);
                        err_d    = sc_err_s;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNTW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_sum_s[WIDTH:1];
                    b_d   = {mul_sum_s[0], b_q[WIDTH-1:1]};
                end else if (div_ge_s) begin
                    acc_d = div_sub_s;
                    b_d   = {b_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = div_shift_s[WIDTH-1:0];
                    b_d   = {b_q[WIDTH-2:0], 1'b0};
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    if (op_q == OP_REMU) begin
                        fin_res_s = acc_d;
                    end else begin
                        fin_res_s = b_d;
                    end
                    result_d = fin_res_s;
                    carry_d  = (op_q == OP_MUL) && (acc_d != '0);
                    ovf_d    = 1'b0;
                    sign_d   = fin_res_s[MSB];
                    z_d      = (fin_res_s == '0);
                    err_d    = 1'b0;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            a_q         <= '0;
            acc_q       <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            sign_q      <= 1'b0;
            ovf_q       <= 1'b0;
            z_q         <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_q         <= a_d;
            acc_q       <= acc_d;
            b_q         <= b_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            sign_q      <= sign_d;
            ovf_q       <= ovf_d;
            z_q         <= z_d;
            err_q       <= err_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign out_valid    = out_valid_q;
    assign ALUResult    = result_q;
    assign carryflag    = carry_q;
    assign signflag     = sign_q;
    assign overflowflag = ovf_q;
    assign zflag        = z_q;
    assign errflag      = err_q;
endmodule

// File: doc/multicycle_alu.md
MULTICYCLE_ALU -- requirements
Module: multicycle_alu

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits (legal range 8..64).
REQ-002 Parameter OPW, default 4, width of alu_control.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 alu_control  input  OPW  operation select, sampled on accept.
REQ-006 operand0  input  WIDTH  first operand, sampled on accept.
REQ-007 operand1  input  WIDTH  second operand, sampled on accept.
REQ-008 in_valid  input  1  request present.
REQ-009 in_ready  output  1  block can accept a request.
REQ-010 out_valid  output  1  result and flags valid.
REQ-011 out_ready  input  1  consumer takes result.
REQ-012 ALUResult  output  WIDTH  registered result.
REQ-013 carryflag, signflag, overflowflag, zflag, errflag  output  1 each  registered flags.

Function
REQ-014 Accept when in_valid and in_ready high on a clock edge; operands and opcode are captured into internal registers.
REQ-015 States IDLE, BUSY, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-016 IDLE -> DONE on accept of single-cycle op (result visible the cycle after accept, latency 1).
REQ-017 IDLE -> BUSY on accept of MUL/DIVU/REMU; BUSY runs exactly WIDTH iterations, then -> DONE (latency WIDTH+1).
REQ-018 DONE -> IDLE when out_ready high; ALUResult and flags hold stable while out_valid high and out_ready low.
REQ-019 No accept in the DONE cycle; back-to-back single-cycle throughput is one result per 2 cycles.
REQ-020 Opcodes: 0 ADD op0+op1; 1 COMP ~op1+1; 2 AND; 3 XOR; 4 SLL op0<<sh; 5 SRL logical; 6 SRA arithmetic (sign fill); 7 SUB op0-op1; 8 MUL low WIDTH bits of unsigned product (shift-add); 9 DIVU unsigned quotient (restoring); 10 REMU unsigned remainder; 11-15 illegal.
REQ-021 Shift amount sh = operand1[$clog2(WIDTH)-1:0]; upper bits of operand1 ignored.
REQ-022 ADD carryflag = carry-out bit WIDTH; SUB carryflag = 1 when no borrow (op0 >= op1 unsigned); MUL carryflag = 1 if upper product half nonzero; other ops carryflag = 0.
REQ-023 overflowflag (ADD/SUB only) = two's-complement signed overflow from operand/result MSBs; 0 for all other ops.
REQ-024 signflag = ALUResult[WIDTH-1] XOR overflowflag (true sign of signed result); zflag = (ALUResult == 0).
REQ-025 DIVU/REMU with operand1 == 0: no iteration, DONE after 1 cycle, quotient = all ones, remainder = operand0, errflag = 1.
REQ-026 Illegal opcode: DONE after 1 cycle, ALUResult = 0, zflag = 1, errflag = 1, other flags 0.
REQ-027 errflag = 0 for all legal non-faulting operations.
REQ-028 Operand input changes after accept have no effect on the in-flight operation.

Reset
REQ-029 reset high forces state IDLE immediately, independent of clk.
REQ-030 During reset: in_ready = 0, out_valid = 0, ALUResult = 0, all flags = 0, iteration counter = 0.
REQ-031 in_ready rises in the first cycle after reset deasserts.
REQ-032 Reset during BUSY or DONE aborts the operation; no result is emitted afterwards.

Verification
REQ-033 ADD 0x7FFFFFFF + 0x00000001 -> out_valid next cycle, ALUResult 0x80000000, overflow 1, sign 0, carry 0, z 0.
REQ-034 SUB 5 - 5 -> ALUResult 0, zflag 1, carryflag 1; SRA 0x80000000 by 0x21 (sh=1) -> 0xC0000000.
REQ-035 MUL 0x00010000 * 0x00010000 -> out_valid exactly 33 cycles after accept, ALUResult 0, carryflag 1, zflag 1.
REQ-036 DIVU 100/7 -> 14 after 33 cycles; REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF, errflag 1, 1-cycle latency.
REQ-037 Hold out_ready low 5 cycles after DONE -> outputs stable, in_ready 0, new in_valid ignored until handshake completes.
REQ-038 Assert reset at cycle 10 of a MUL -> out_valid never rises for it; after release, ADD 2+3 returns 5.
